kmeans_seq: RTL and testbench

KMEANS_SEQ -- requirements
Module: kmeans_seq

---
 rtl/kmeans_seq.sv | 175 +++++++++++++++++
 tb/tb_kmeans_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/kmeans_seq.sv
// kmeans_seq: control sequencer for an iterative k-means datapath (load, assign, update, check, output).
// Optional macro KMEANS_SEQ_EARLY_EXIT_EN stops iterating once an iteration changes no label.
module kmeans_seq #(
  parameter int N_PTS    = 64,
  parameter int K        = 4,
  parameter int MAX_ITER = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     mem_we,
  output logic [$clog2(N_PTS)-1:0] mem_addr,
  output logic                     dist_start,
  input  logic                     dist_done,
  input  logic                     dist_chg,
  output logic                     acc_clr,
  output logic                     acc_en,
  output logic                     div_start,
  input  logic                     div_done,
  output logic [2:0]               ctr_idx,
  output logic                     ctr_we,
  output logic                     out_valid,
  output logic                     busy,
  output logic [3:0]               iter_cnt
);

  localparam int AW = $clog2(N_PTS);

`ifdef KMEANS_SEQ_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  // ASSIGN and UPDATE are split into sub-states so every strobe is a plain register
  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_A_CLR, S_A_WAIT, S_A_ACC,
    S_U_WAIT, S_U_WE, S_CHECK, S_OUT
  } state_t;

  state_t          state_q;
  logic [AW-1:0]   cnt_q;
  logic [2:0]      idx_q;
  logic [3:0]      iter_q;
  logic [3:0]      iter_d;
  logic            chg_q;
  logic            dist_start_q, acc_clr_q, acc_en_q, div_start_q, ctr_we_q, out_valid_q;
  logic            last_pt, last_ctr, exit_now;
  logic [4:0]      iter_inc;

  always_comb begin
    last_pt  = (cnt_q == AW'(N_PTS - 1));
    last_ctr = (idx_q == 3'(K - 1));
    iter_inc = {1'b0, iter_q} + 5'd1;
    iter_d   = (iter_q == 4'hF) ? iter_q : iter_inc[3:0];
    exit_now = (iter_inc == 5'(MAX_ITER)) || (EARLY_EXIT && !chg_q);
    // The first beat is written in the IDLE cycle itself, so the write enable is combinational
    mem_we   = in_valid && !rst && ((state_q == S_IDLE) || (state_q == S_LOAD));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      iter_q       <= '0;
      chg_q        <= 1'b0;
      dist_start_q <= 1'b0;
      acc_clr_q    <= 1'b0;
      acc_en_q     <= 1'b0;
      div_start_q  <= 1'b0;
      ctr_we_q     <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      acc_clr_q <= 1'b0;
      acc_en_q  <= 1'b0;
      ctr_we_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            state_q <= S_LOAD;
            cnt_q   <= AW'(1);
            iter_q  <= '0;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            if (last_pt) begin
              state_q   <= S_A_CLR;
              acc_clr_q <= 1'b1;
              chg_q     <= 1'b0;
              cnt_q     <= '0;
            end else begin
              cnt_q <= cnt_q + AW'(1);
            end
          end
        end
        S_A_CLR: begin
          state_q      <= S_A_WAIT;
          dist_start_q <= 1'b1;
        end
        S_A_WAIT: begin
          dist_start_q <= 1'b0;
          if (dist_done) begin
            state_q  <= S_A_ACC;
            acc_en_q <= 1'b1;
            chg_q    <= chg_q | dist_chg;
          end
        end
        S_A_ACC: begin
          if (last_pt) begin
            state_q     <= S_U_WAIT;
            div_start_q <= 1'b1;
            cnt_q       <= '0;
            idx_q       <= '0;
          end else begin
            state_q      <= S_A_WAIT;
            dist_start_q <= 1'b1;
            cnt_q        <= cnt_q + AW'(1);
          end
        end
        S_U_WAIT: begin
          div_start_q <= 1'b0;
          if (div_done) begin
            state_q  <= S_U_WE;
            ctr_we_q <= 1'b1;
          end
        end
        S_U_WE: begin
          if (last_ctr) begin
            state_q <= S_CHECK;
          end else begin
            state_q     <= S_U_WAIT;
            idx_q       <= idx_q + 3'd1;
            div_start_q <= 1'b1;
          end
        end
        S_CHECK: begin
          iter_q <= iter_d;
          idx_q  <= '0;
          if (exit_now) begin
            state_q     <= S_OUT;
            out_valid_q <= 1'b1;
          end else begin
            state_q   <= S_A_CLR;
            acc_clr_q <= 1'b1;
            chg_q     <= 1'b0;
          end
        end
        S_OUT: begin
          if (last_pt) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
          end else begin
            cnt_q <= cnt_q + AW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_addr   = cnt_q;
  assign dist_start = dist_start_q;
  assign acc_clr    = acc_clr_q;
  assign acc_en     = acc_en_q;
  assign div_start  = div_start_q;
  assign ctr_idx    = idx_q;
  assign ctr_we     = ctr_we_q;
  assign out_valid  = out_valid_q;
  assign busy       = (state_q != S_IDLE);
  assign iter_cnt   = iter_q;

endmodule

// File: tb/tb_kmeans_seq.sv
// Directed bench for kmeans_seq: responder processes model the distance and divider units.
module tb_kmeans_seq;
  localparam int N  = 64;
  localparam int KK = 4;
  localparam int MI = 15;
  localparam int AW = $clog2(N);
`ifdef KMEANS_SEQ_EARLY_EXIT_EN
  localparam int EXP_IT2 = 3;
`else
  localparam int EXP_IT2 = 15;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic dist_done = 1'b0, dist_chg = 1'b0, div_done = 1'b0;
  logic mem_we, dist_start, acc_clr, acc_en, div_start, ctr_we, out_valid, busy;
  logic [AW-1:0] mem_addr;
  logic [2:0] ctr_idx;
  logic [3:0] iter_cnt;

  int tests = 0, fails = 0;
  int dlat = 2, vlat = 1, chg_mode = 0;
  bit hold2 = 0, spur = 0;
  int dcnt = 0, vcnt = 0;
  int n_we, n_clr, n_acc, n_ds, n_dv, n_cw, n_out;
  int we_bad, ds_bad, cw_bad, out_bad, excl_bad;

  kmeans_seq #(.N_PTS(N), .K(KK), .MAX_ITER(MI)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .dist_start(dist_start), .dist_done(dist_done), .dist_chg(dist_chg),
    .acc_clr(acc_clr), .acc_en(acc_en), .div_start(div_start), .div_done(div_done),
    .ctr_idx(ctr_idx), .ctr_we(ctr_we), .out_valid(out_valid), .busy(busy), .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  // Distance unit: answers dlat cycles after dist_start (0 = same cycle)
  always @(negedge clk) begin
    dist_done = 1'b0;
    dist_chg  = 1'b0;
    if (rst) dcnt = 0;
    else begin
      if (dcnt != 0) begin
        dcnt--;
        if (dcnt == 0) begin
          dist_done = 1'b1;
          dist_chg  = (chg_mode == 0) ? 1'b1 : (iter_cnt != 4'd2);
        end
      end
      if (dist_start) begin
        if (dlat == 0) begin
          dist_done = 1'b1;
          dist_chg  = (chg_mode == 0) ? 1'b1 : (iter_cnt != 4'd2);
        end else dcnt = dlat;
      end
    end
  end

  // Divider: answers vlat cycles after div_start; may stall on centroid 2 or fire spuriously
  always @(negedge clk) begin
    div_done = 1'b0;
    if (rst) vcnt = 0;
    else begin
      if (vcnt != 0) begin
        vcnt--;
        if (vcnt == 0) div_done = 1'b1;
      end
      if (div_start && !(hold2 && ctr_idx == 3'd2)) begin
        if (vlat == 0) div_done = 1'b1;
        else vcnt = vlat;
      end
      if (spur && dist_start) div_done = 1'b1;
    end
  end

  // Strobe monitor; counters restart on the IDLE beat that opens a job
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we && !busy) begin
        n_we = 0; n_clr = 0; n_acc = 0; n_ds = 0; n_dv = 0; n_cw = 0; n_out = 0;
        we_bad = 0; ds_bad = 0; cw_bad = 0; out_bad = 0; excl_bad = 0;
      end
      if (int'(mem_we) + int'(dist_start) + int'(acc_clr) + int'(acc_en) +
          int'(div_start) + int'(ctr_we) + int'(out_valid) > 1) excl_bad++;
      if (mem_we) begin
        if (int'(mem_addr) != n_we) we_bad++;
        n_we++;
      end
      if (dist_start) begin
        if (int'(mem_addr) != (n_ds % N)) ds_bad++;
        n_ds++;
      end
      if (acc_clr) n_clr++;
      if (acc_en) n_acc++;
      if (div_start) n_dv++;
      if (ctr_we) begin
        if (int'(ctr_idx) != (n_cw % KK)) cw_bad++;
        n_cw++;
      end
      if (out_valid) begin
        if (int'(mem_addr) != n_out) out_bad++;
        n_out++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int gap, input bit keep_high);
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      tick();
      if (gap > 0) begin
        in_valid = 1'b0;
        repeat (gap) tick();
      end
    end
    in_valid = keep_high;
  endtask

  task automatic wait_idle(input string tag, input bit drop_iv);
    int n = 0;
    while (busy === 1'b1 && n < 30000) begin
      if (drop_iv && out_valid && mem_addr == AW'(N - 1)) in_valid = 1'b0;
      tick();
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  function automatic logic [31:0] outs();
    return 32'({mem_we, dist_start, acc_clr, acc_en, div_start, ctr_we, out_valid, busy,
                mem_addr, ctr_idx, iter_cnt});
  endfunction

  task automatic check_full_job(input string tag, input int iters);
    check({tag, "_iter"},   32'(iter_cnt), 32'(iters));
    check({tag, "_acc"},    32'(n_acc), 32'(N * iters));
    check({tag, "_ds"},     32'(n_ds), 32'(N * iters));
    check({tag, "_dsaddr"}, 32'(ds_bad), 32'd0);
    check({tag, "_clr"},    32'(n_clr), 32'(iters));
    check({tag, "_divst"},  32'(n_dv), 32'(KK * iters));
    check({tag, "_ctrwe"},  32'(n_cw), 32'(KK * iters));
    check({tag, "_ctridx"}, 32'(cw_bad), 32'd0);
    check({tag, "_out"},    32'(n_out), 32'(N));
    check({tag, "_outadr"}, 32'(out_bad), 32'd0);
    check({tag, "_we"},     32'(n_we), 32'(N));
    check({tag, "_excl"},   32'(excl_bad), 32'd0);
  endtask

  initial begin
    // Reset with in_valid high: everything must read zero
    in_valid = 1'b1;
    repeat (2) tick();
    check("rst_outs", outs(), 32'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Job 1: gapped load, 2-cycle distance latency, labels always change
    dlat = 2; vlat = 1; chg_mode = 0;
    load(3, 1'b0);
    check("load_we", 32'(n_we), 32'(N));
    check("load_addr", 32'(we_bad), 32'd0);
    check("load_clr", 32'(n_clr), 32'd1);
    check("load_busy", 32'(busy), 32'd1);
    wait_idle("j1_done", 1'b0);
    check_full_job("j1", MI);
    repeat (3) tick();
    check("idle_iter_hold", 32'(iter_cnt), 32'd15);

    // Job 2: same-cycle answers, labels settle in iteration 3
    dlat = 0; vlat = 0; chg_mode = 1;
    load(0, 1'b0);
    check("j2_iter_clear", 32'(iter_cnt), 32'd0);
    wait_idle("j2_done", 1'b0);
    check_full_job("j2", EXP_IT2);

    // Job 3: reset while stalled on centroid 2
    dlat = 2; vlat = 1; chg_mode = 0; hold2 = 1'b1;
    load(0, 1'b0);
    begin
      int n = 0;
      while (!(div_start && ctr_idx == 3'd2) && n < 5000) begin
        tick();
        n++;
      end
    end
    repeat (3) tick();
    check("j3_stall_idx", 32'(ctr_idx), 32'd2);
    check("j3_stall_busy", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    in_valid = 1'b1;
    #1 check("j3_rst_outs", outs(), 32'd0);
    tick();
    check("j3_rst_hold", outs(), 32'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    hold2 = 1'b0;
    tick();
    check("j3_post_busy", 32'(busy), 32'd0);

    // Job 4: in_valid held high through ASSIGN/OUT, spurious div_done during ASSIGN
    spur = 1'b1;
    load(0, 1'b1);
    wait_idle("j4_done", 1'b1);
    check_full_job("j4", MI);
    spur = 1'b0;
    tick();
    check("j4_idle_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
